// File: rtl/cargador_entradas.sv
// Purpose : write end of the 4-entry work buffer; loads (bounty, target) batches from the host.
// Latency : final accept at edge t -> listo/num_entradas from t+1; read port is zero-cycle.
// Backpressure: in_ready is high only while loading (CARGA); the host must hold data while listo.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   in_valid/in_ready           host entry handshake; bounty_in, target_in, last_in carry the entry
//   rd_ptr -> bounty, target    combinational read of the stored entry
//   num_entradas                index of the last stored entry (count - 1)
//   listo                       batch loaded, engine may start
//   fin                         output stage done (level); its rising edge re-arms the loader
module cargador_entradas #(
    parameter int BOUNTY_W = 24,
    parameter int TARGET_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BOUNTY_W-1:0] bounty_in,
    input  logic [TARGET_W-1:0] target_in,
    input  logic                last_in,
    input  logic [1:0]          rd_ptr,
    output logic [BOUNTY_W-1:0] bounty,
    output logic [TARGET_W-1:0] target,
    output logic [1:0]          num_entradas,
    output logic                listo,
    input  logic                fin
);

    typedef struct packed {
        logic [BOUNTY_W-1:0] bounty;
        logic [TARGET_W-1:0] target;
    } entry_t;

    typedef enum logic {
        CARGA = 1'b0,
        LISTO = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  wr_ptr;
    logic        fin_q;
    entry_t      mem [4];

    logic        accept;
    logic        close_batch;
    logic        fin_rise;

    assign accept      = in_valid & in_ready;
    // Slot 3 always closes the batch, so the buffer can never overflow.
    assign close_batch = accept & (last_in | (wr_ptr == 2'd3));
    // Edge-detect so a fin level left high from the previous batch cannot re-arm twice.
    assign fin_rise    = fin & ~fin_q;

    // Handshake outputs come from the registered state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        listo     = 1'b0;
        case (state)
            CARGA: begin
                in_ready = 1'b1;
                if (close_batch) begin
                    state_nxt = LISTO;
                end
            end
            LISTO: begin
                listo = 1'b1;
                if (fin_rise) begin
                    state_nxt = CARGA;
                end
            end
            default: state_nxt = CARGA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CARGA;
            wr_ptr       <= 2'd0;
            num_entradas <= 2'd0;
            fin_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            fin_q <= fin;
            if (accept) begin
                mem[wr_ptr] <= '{bounty: bounty_in, target: target_in};
                if (close_batch) begin
                    num_entradas <= wr_ptr;
                    wr_ptr       <= 2'd0;
                end else begin
                    wr_ptr       <= wr_ptr + 2'd1;
                end
            end
        end
    end

    assign bounty = mem[rd_ptr].bounty;
    assign target = mem[rd_ptr].target;

endmodule

// File: tb/tb_cargador_entradas.sv
// Purpose : directed self-checking bench for cargador_entradas.
// Latency : each vector is checked before the edge that applies it.
// Backpressure: exercises host data held against in_ready=0 while listo.
module tb_cargador_entradas;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] bounty_in;
    logic [7:0]  target_in;
    logic        last_in;
    logic [1:0]  rd_ptr;
    logic [23:0] bounty;
    logic [7:0]  target;
    logic [1:0]  num_entradas;
    logic        listo;
    logic        fin;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cargador_entradas #(.BOUNTY_W(24), .TARGET_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bounty_in    (bounty_in),
        .target_in    (target_in),
        .last_in      (last_in),
        .rd_ptr       (rd_ptr),
        .bounty       (bounty),
        .target       (target),
        .num_entradas (num_entradas),
        .listo        (listo),
        .fin          (fin)
    );

    typedef struct {
        logic        vld;
        logic [23:0] b;
        logic [7:0]  t;
        logic        last;
        logic [1:0]  rd;
        logic        fin;
        logic        rdy;
        logic        lst;
        logic [1:0]  num;
        logic [23:0] eb;
        logic [7:0]  et;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic vld, input logic [23:0] b, input logic [7:0] t,
                                input logic last, input logic [1:0] rd, input logic f,
                                input logic rdy, input logic lst, input logic [1:0] num,
                                input logic [23:0] eb, input logic [7:0] et);
        vec_t v;
        v.vld = vld; v.b = b; v.t = t; v.last = last; v.rd = rd; v.fin = f;
        v.rdy = rdy; v.lst = lst; v.num = num; v.eb = eb; v.et = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string name, input logic [1:0] p,
                          input logic [23:0] eb, input logic [7:0] et);
        rd_ptr = p;
        #1;
        chk({name, "_bounty"}, {8'd0, bounty}, {8'd0, eb});
        chk({name, "_target"}, {24'd0, target}, {24'd0, et});
    endtask

    task automatic chk_ctl(input string name, input logic rdy, input logic lst, input logic [1:0] num);
        chk({name, "_in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
        chk({name, "_listo"}, {31'd0, listo}, {31'd0, lst});
        chk({name, "_num"}, {30'd0, num_entradas}, {30'd0, num});
    endtask

    task automatic drive(input logic vld, input logic [23:0] b, input logic [7:0] t, input logic last);
        in_valid  = vld;
        bounty_in = b;
        target_in = t;
        last_in   = last;
    endtask

    initial begin
        // 4 back-to-back entries, expected outputs are pre-edge values
        tbl[0]  = mk(1, 24'h000011, 8'h01, 0, 0, 0, 1, 0, 0, 24'h000000, 8'h00);
        tbl[1]  = mk(1, 24'h000022, 8'h02, 0, 0, 0, 1, 0, 0, 24'h000011, 8'h01);
        tbl[2]  = mk(1, 24'h000033, 8'h03, 0, 1, 0, 1, 0, 0, 24'h000022, 8'h02);
        tbl[3]  = mk(1, 24'h000044, 8'h04, 0, 2, 0, 1, 0, 0, 24'h000033, 8'h03);
        tbl[4]  = mk(0, 24'h000000, 8'h00, 0, 3, 0, 0, 1, 3, 24'h000044, 8'h04);
        tbl[5]  = mk(0, 24'h000000, 8'h00, 0, 0, 0, 0, 1, 3, 24'h000011, 8'h01);
        // host holds new data in LISTO for 5 cycles
        tbl[6]  = mk(1, 24'hDEAD00, 8'hFF, 1, 0, 0, 0, 1, 3, 24'h000011, 8'h01);
        tbl[7]  = mk(1, 24'hDEAD00, 8'hFF, 1, 1, 0, 0, 1, 3, 24'h000022, 8'h02);
        tbl[8]  = mk(1, 24'hDEAD00, 8'hFF, 1, 2, 0, 0, 1, 3, 24'h000033, 8'h03);
        tbl[9]  = mk(1, 24'hDEAD00, 8'hFF, 1, 3, 0, 0, 1, 3, 24'h000044, 8'h04);
        tbl[10] = mk(1, 24'hDEAD00, 8'hFF, 1, 0, 0, 0, 1, 3, 24'h000011, 8'h01);
        tbl[11] = mk(0, 24'h000000, 8'h00, 0, 1, 0, 0, 1, 3, 24'h000022, 8'h02);
        // fin pulse, then 2-entry batch ending with last_in
        tbl[12] = mk(0, 24'h000000, 8'h00, 0, 0, 1, 0, 1, 3, 24'h000011, 8'h01);
        tbl[13] = mk(1, 24'h000AAA, 8'h0A, 0, 0, 0, 1, 0, 3, 24'h000011, 8'h01);
        tbl[14] = mk(1, 24'hABCDEF, 8'h0F, 1, 0, 0, 1, 0, 3, 24'h000AAA, 8'h0A);
        tbl[15] = mk(0, 24'h000000, 8'h00, 0, 1, 0, 0, 1, 1, 24'hABCDEF, 8'h0F);
        tbl[16] = mk(0, 24'h000000, 8'h00, 0, 2, 0, 0, 1, 1, 24'h000033, 8'h03);
        // re-arm, then valid with gaps 1,0,1,0,1,1
        tbl[17] = mk(0, 24'h000000, 8'h00, 0, 0, 1, 0, 1, 1, 24'h000AAA, 8'h0A);
        tbl[18] = mk(1, 24'h000100, 8'h10, 0, 0, 0, 1, 0, 1, 24'h000AAA, 8'h0A);
        tbl[19] = mk(0, 24'h000000, 8'h00, 0, 0, 0, 1, 0, 1, 24'h000100, 8'h10);
        tbl[20] = mk(1, 24'h000200, 8'h20, 0, 1, 0, 1, 0, 1, 24'hABCDEF, 8'h0F);
        tbl[21] = mk(0, 24'h000000, 8'h00, 0, 1, 0, 1, 0, 1, 24'h000200, 8'h20);
        tbl[22] = mk(1, 24'h000300, 8'h30, 0, 2, 0, 1, 0, 1, 24'h000033, 8'h03);
        tbl[23] = mk(1, 24'h000400, 8'h40, 1, 3, 0, 1, 0, 1, 24'h000044, 8'h04);
        tbl[24] = mk(0, 24'h000000, 8'h00, 0, 3, 0, 0, 1, 3, 24'h000400, 8'h40);
        tbl[25] = mk(0, 24'h000000, 8'h00, 0, 2, 0, 0, 1, 3, 24'h000300, 8'h30);

        reset = 1'b1;
        drive(0, 24'd0, 8'd0, 0);
        rd_ptr = 2'd0;
        fin = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_ctl("reset", 1, 0, 0);
        chk_rd("reset_rd0", 0, 24'd0, 8'd0);
        chk_rd("reset_rd3", 3, 24'd0, 8'd0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].vld, tbl[i].b, tbl[i].t, tbl[i].last);
            rd_ptr = tbl[i].rd;
            fin    = tbl[i].fin;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("vec%0d_listo", i), {31'd0, listo}, {31'd0, tbl[i].lst});
            chk($sformatf("vec%0d_num", i), {30'd0, num_entradas}, {30'd0, tbl[i].num});
            chk($sformatf("vec%0d_bounty", i), {8'd0, bounty}, {8'd0, tbl[i].eb});
            chk($sformatf("vec%0d_target", i), {24'd0, target}, {24'd0, tbl[i].et});
            tick();
        end

        // fin rises and stays high: one re-arm only
        drive(0, 24'd0, 8'd0, 0);
        fin = 1'b1;
        tick();
        chk_ctl("fin_rearm", 1, 0, 3);
        drive(1, 24'h000555, 8'h55, 1);
        tick();
        drive(0, 24'd0, 8'd0, 0);
        #1;
        chk_ctl("single_entry", 0, 1, 0);
        chk_rd("single_rd0", 0, 24'h000555, 8'h55);
        drive(1, 24'h000666, 8'h66, 1);
        for (int k = 0; k < 4; k++) tick();
        chk_ctl("fin_level_hold", 0, 1, 0);
        chk_rd("fin_level_rd0", 0, 24'h000555, 8'h55);

        // reset in the middle of a batch
        drive(0, 24'd0, 8'd0, 0);
        fin = 1'b0;
        tick();
        fin = 1'b1;
        tick();
        fin = 1'b0;
        drive(1, 24'h000777, 8'h77, 0);
        tick();
        drive(1, 24'h000888, 8'h88, 0);
        tick();
        drive(0, 24'd0, 8'd0, 0);
        chk_rd("pre_reset_rd1", 1, 24'h000888, 8'h88);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk_ctl("midreset", 1, 0, 0);
        chk_rd("midreset_rd0", 0, 24'd0, 8'd0);
        chk_rd("midreset_rd1", 1, 24'd0, 8'd0);
        drive(1, 24'h000999, 8'h99, 1);
        tick();
        drive(0, 24'd0, 8'd0, 0);
        #1;
        chk_ctl("post_reset_batch", 0, 1, 0);
        chk_rd("post_reset_rd0", 0, 24'h000999, 8'h99);
        chk_rd("post_reset_rd2", 2, 24'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
